// File: rtl/div_unit.sv
// Restoring radix-2 divider for DIV/DIVU: one quotient bit per clock on operand
// magnitudes, then a single sign-fixup cycle that registers HI (remainder) and LO (quotient).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_is_signed,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div_by_zero,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_dvd;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;

    logic             w_launch;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // Abort beats a coincident start, so a flushed launch never begins.
    assign w_launch  = i_start && !i_abort && (r_state == S_IDLE || r_state == S_DONE);
    assign w_dvd_neg = i_is_signed & i_dividend[WIDTH-1];
    assign w_dvs_neg = i_is_signed & i_divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
    assign w_dvs_mag = w_dvs_neg ? -i_divisor  : i_divisor;

    // The shifted remainder carries one extra bit so the compare cannot overflow;
    // after a successful subtract the result is below the divisor and fits WIDTH bits.
    assign w_rem_sh = {r_rem, r_q[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_dvsr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = w_launch ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_abort) w_next = S_IDLE;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
            r_dvd    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_sign_q <= w_dvd_neg ^ w_dvs_neg;
                r_sign_r <= w_dvd_neg;
                r_q      <= w_dvd_mag;
                r_dvsr   <= w_dvs_mag;
                r_dvd    <= i_dividend;
                r_rem    <= '0;
                r_cnt    <= '0;
            end else if (r_state == S_RUN && !i_abort) begin
                r_rem <= w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], w_ge};
                r_cnt <= r_cnt + CW'(1);
            end else if (r_state == S_FIX && !i_abort) begin
                if (r_dvsr == '0) begin
                    r_lo  <= {WIDTH{1'b1}};
                    r_hi  <= r_dvd;
                    r_dbz <= 1'b1;
                end else begin
                    r_lo  <= r_sign_q ? -r_q : r_q;
                    r_hi  <= r_sign_r ? -r_rem : r_rem;
                    r_dbz <= 1'b0;
                end
            end
        end
    end

    assign o_busy        = (r_state == S_RUN) || (r_state == S_FIX);
    assign o_done        = (r_state == S_DONE);
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;
    assign o_div_by_zero = r_dbz;
    assign o_state       = r_state;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed scenarios plus random operands, checked through
// an expected-result queue filled at launch and drained when done pulses.
module tb_div_unit;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES  = {W{1'b1}};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         i_reset = 1'b1;
  logic         i_start = 1'b0;
  logic         i_is_signed = 1'b0;
  logic         i_abort = 1'b0;
  logic [W-1:0] i_dividend = '0;
  logic [W-1:0] i_divisor = '0;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_hi;
  logic [W-1:0] o_lo;
  logic         o_div_by_zero;
  logic [1:0]   o_state;

  div_unit #(.WIDTH(W)) dut (
    .i_clock(clk),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_is_signed(i_is_signed),
    .i_abort(i_abort),
    .i_dividend(i_dividend),
    .i_divisor(i_divisor),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_hi(o_hi),
    .o_lo(o_lo),
    .o_div_by_zero(o_div_by_zero),
    .o_state(o_state)
  );

  int n_tests = 0;
  int n_fail = 0;

  // scoreboard
  logic [W-1:0] exp_lo_q[$];
  logic [W-1:0] exp_hi_q[$];
  logic         exp_dbz_q[$];
  logic [W-1:0] last_lo = '0;
  logic [W-1:0] last_hi = '0;
  logic         last_dbz = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dbz);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    dbz = 1'b0;
    if (b == '0) begin
      lo = ONES;
      hi = a;
      dbz = 1'b1;
    end else if (sgn && a == MIN_V && b == ONES) begin
      lo = MIN_V;
      hi = '0;
    end else if (sgn) begin
      lo = W'(sa / sb);
      hi = W'(sa % sb);
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // driver: one-cycle start pulse; the edge it sees is the capture edge
  task automatic drive_launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    logic [W-1:0] elo;
    logic [W-1:0] ehi;
    logic edbz;
    model(a, b, sgn, elo, ehi, edbz);
    exp_lo_q.push_back(elo);
    exp_hi_q.push_back(ehi);
    exp_dbz_q.push_back(edbz);
    i_dividend = a;
    i_divisor = b;
    i_is_signed = sgn;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // scoreboard consumer: k is the cycle index after the capture edge (1 = first busy cycle)
  task automatic collect(input string name, input int k0);
    int k;
    bit got;
    bit tim_ok;
    logic [W-1:0] elo;
    logic [W-1:0] ehi;
    logic edbz;
    k = k0;
    got = 1'b0;
    tim_ok = 1'b1;
    while (!got && k <= W + 8) begin
      if (o_done === 1'b1) begin
        got = 1'b1;
        if (k != W + 2 || o_busy !== 1'b0) tim_ok = 1'b0;
      end else begin
        if (o_busy !== (k <= W + 1)) tim_ok = 1'b0;
        tick();
        k++;
      end
    end
    n_tests++;
    if (!got || !tim_ok) begin
      n_fail++;
      $display("FAIL %s timing: done_seen=%0d at cycle %0d, required done at cycle %0d with busy before", name, got, k, W + 2);
    end
    if (got) begin
      n_tests++;
      if (exp_lo_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s scoreboard: done with empty expected queue", name);
      end else begin
        elo = exp_lo_q.pop_front();
        ehi = exp_hi_q.pop_front();
        edbz = exp_dbz_q.pop_front();
        if (o_lo !== elo) begin
          n_fail++;
          $display("FAIL %s lo: got %h expected %h", name, o_lo, elo);
        end
        n_tests++;
        if (o_hi !== ehi) begin
          n_fail++;
          $display("FAIL %s hi: got %h expected %h", name, o_hi, ehi);
        end
        n_tests++;
        if (o_div_by_zero !== edbz) begin
          n_fail++;
          $display("FAIL %s dbz: got %b expected %b", name, o_div_by_zero, edbz);
        end
        last_lo = elo;
        last_hi = ehi;
        last_dbz = edbz;
      end
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    n_tests++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_div_by_zero !== 1'b0 || o_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b dbz=%b state=%0d expected 0 0 0 0", o_busy, o_done, o_div_by_zero, o_state);
    end
    n_tests++;
    if (o_hi !== '0 || o_lo !== '0) begin
      n_fail++;
      $display("FAIL reset_data: hi=%h lo=%h expected 0 0", o_hi, o_lo);
    end
  endtask

  task automatic test_divu();
    drive_launch(32'd100, 32'd7, 1'b0);
    collect("divu_100_7", 1);
    n_tests++;
    if (o_lo !== 32'd14 || o_hi !== 32'd2) begin
      n_fail++;
      $display("FAIL divu_const: lo=%0d hi=%0d expected 14 2", o_lo, o_hi);
    end
    tick();
    n_tests++;
    if (o_done !== 1'b0 || o_lo !== 32'd14 || o_hi !== 32'd2) begin
      n_fail++;
      $display("FAIL divu_hold: done=%b lo=%0d hi=%0d expected 0 14 2", o_done, o_lo, o_hi);
    end
  endtask

  task automatic test_signed();
    drive_launch(32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    collect("div_m7_2", 1);
    n_tests++;
    if (o_lo !== 32'hFFFF_FFFD || o_hi !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL div_m7_2_const: lo=%h hi=%h expected fffffffd ffffffff", o_lo, o_hi);
    end
    tick();
    drive_launch(32'd7, 32'hFFFF_FFFE, 1'b1);
    collect("div_7_m2", 1);
    n_tests++;
    if (o_lo !== 32'hFFFF_FFFD || o_hi !== 32'd1) begin
      n_fail++;
      $display("FAIL div_7_m2_const: lo=%h hi=%h expected fffffffd 00000001", o_lo, o_hi);
    end
    tick();
  endtask

  task automatic test_overflow();
    drive_launch(MIN_V, ONES, 1'b1);
    collect("div_overflow", 1);
    n_tests++;
    if (o_lo !== MIN_V || o_hi !== '0 || o_div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL div_overflow_const: lo=%h hi=%h dbz=%b expected 80000000 0 0", o_lo, o_hi, o_div_by_zero);
    end
    tick();
    drive_launch(MIN_V, ONES, 1'b0);
    collect("divu_min_ones", 1);
    n_tests++;
    if (o_lo !== '0 || o_hi !== MIN_V) begin
      n_fail++;
      $display("FAIL divu_min_ones_const: lo=%h hi=%h expected 0 80000000", o_lo, o_hi);
    end
    tick();
  endtask

  task automatic test_div_by_zero();
    drive_launch(32'h1234_5678, 32'd0, 1'b0);
    collect("divu_by_zero", 1);
    n_tests++;
    if (o_div_by_zero !== 1'b1 || o_lo !== ONES || o_hi !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL divu_by_zero_const: dbz=%b lo=%h hi=%h expected 1 ffffffff 12345678", o_div_by_zero, o_lo, o_hi);
    end
    tick();
    drive_launch(32'hFFFF_FFFB, 32'd0, 1'b1);
    collect("div_by_zero_neg", 1);
    tick();
  endtask

  task automatic test_abort();
    bit saw_done;
    drive_launch(32'd100, 32'd7, 1'b0);
    void'(exp_lo_q.pop_back());
    void'(exp_hi_q.pop_back());
    void'(exp_dbz_q.pop_back());
    repeat (8) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    n_tests++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: busy=%b expected 0", o_busy);
    end
    saw_done = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      if (o_done !== 1'b0) saw_done = 1'b1;
      tick();
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL abort_no_done: done seen=1 expected 0");
    end
    n_tests++;
    if (o_lo !== last_lo || o_hi !== last_hi || o_div_by_zero !== last_dbz) begin
      n_fail++;
      $display("FAIL abort_hold: lo=%h hi=%h dbz=%b expected %h %h %b", o_lo, o_hi, o_div_by_zero, last_lo, last_hi, last_dbz);
    end
  endtask

  task automatic test_reset_midop();
    bit saw_done;
    drive_launch(32'd100, 32'd7, 1'b0);
    void'(exp_lo_q.pop_back());
    void'(exp_hi_q.pop_back());
    void'(exp_dbz_q.pop_back());
    repeat (8) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    n_tests++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_lo !== '0 || o_hi !== '0 || o_div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop: busy=%b done=%b lo=%h hi=%h dbz=%b expected all 0", o_busy, o_done, o_lo, o_hi, o_div_by_zero);
    end
    last_lo = '0;
    last_hi = '0;
    last_dbz = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      if (o_done !== 1'b0) saw_done = 1'b1;
      tick();
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_midop_no_done: done seen=1 expected 0");
    end
  endtask

  task automatic test_abort_start();
    bit saw_busy;
    i_dividend = 32'd9;
    i_divisor = 32'd4;
    i_is_signed = 1'b0;
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      if (o_busy !== 1'b0 || o_done !== 1'b0) saw_busy = 1'b1;
      tick();
    end
    n_tests++;
    if (saw_busy) begin
      n_fail++;
      $display("FAIL abort_start: busy/done seen=1 expected 0");
    end
  endtask

  task automatic test_back_to_back();
    drive_launch(32'd50, 32'd5, 1'b0);
    repeat (3) tick();
    i_dividend = 32'd9;
    i_divisor = 32'd4;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_tests++;
    if (o_lo !== last_lo || o_hi !== last_hi) begin
      n_fail++;
      $display("FAIL busy_start_hold: lo=%h hi=%h expected %h %h", o_lo, o_hi, last_lo, last_hi);
    end
    collect("b2b_first", 5);
    n_tests++;
    if (o_lo !== 32'd10 || o_hi !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_first_const: lo=%0d hi=%0d expected 10 0", o_lo, o_hi);
    end
    drive_launch(32'd9, 32'd4, 1'b0);
    collect("b2b_second", 1);
    n_tests++;
    if (o_lo !== 32'd2 || o_hi !== 32'd1) begin
      n_fail++;
      $display("FAIL b2b_second_const: lo=%0d hi=%0d expected 2 1", o_lo, o_hi);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic sgn;
    for (int i = 0; i < 24; i++) begin
      a = $urandom();
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = -W'($urandom_range(1, 15));
        3: begin a = MIN_V; b = ONES; end
        default: b = $urandom();
      endcase
      drive_launch(a, b, sgn);
      collect("random", 1);
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_overflow();
    test_div_by_zero();
    test_abort();
    test_reset_midop();
    test_abort_start();
    test_back_to_back();
    test_random();
    n_tests++;
    if (exp_lo_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: %0d entries remain, expected 0", exp_lo_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
